// File: rtl/rr_pri_arbiter_pkg.sv
// Shared types and helpers for the 8-way round-robin / fixed-priority arbiter.
// Provides the FSM state enum, default sizing and the 8-to-3 encode functions.
package arb_pkg;

    localparam int N    = 8;
    localparam int IDXW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Highest set bit wins; returns 0 for an all-zero vector.
    function automatic logic [IDXW-1:0] pri_enc(input logic [N-1:0] v);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) idx = IDXW'(i);
        end
        return idx;
    endfunction

    function automatic logic [IDXW-1:0] onehot_to_idx(input logic [N-1:0] oh);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) idx = idx | IDXW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pri_arbiter_pick.sv
// Combinational winner selection: fixed priority (highest index) or rotating
// priority starting just below the last winner, using a double-width rotate.
module rot_pri_pick #(
    parameter int N    = arb_pkg::N,
    parameter int IDXW = arb_pkg::IDXW
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] last,
    input  logic            mode,
    output logic            any,
    output logic [IDXW-1:0] win_idx,
    output logic [N-1:0]    win_onehot
);
    import arb_pkg::*;

    logic [IDXW-1:0]  shamt;
    logic [2*N-1:0]   dbl_req;
    logic [N-1:0]     rot_req;
    logic [IDXW-1:0]  rot_idx;
    logic [N-1:0]     rot_oh;
    logic [2*N-1:0]   dbl_oh;

    // rot_req[k] = req[(k + last) mod N], so rot_req[N-1] is req[last-1]:
    // the top of the rotated vector is the first candidate in the search.
    always_comb begin
        shamt      = mode ? last : '0;
        dbl_req    = {req, req} >> shamt;
        rot_req    = dbl_req[N-1:0];
        rot_idx    = pri_enc(rot_req);
        rot_oh     = N'(1) << rot_idx;
        dbl_oh     = {rot_oh, rot_oh} << shamt;
        any        = |req;
        win_onehot = any ? dbl_oh[2*N-1:N] : '0;
        win_idx    = onehot_to_idx(win_onehot);
    end

endmodule

// File: rtl/rr_pri_arbiter.sv
// Registered 8-requester arbiter: grants are held until done, request drop,
// disable or hold timeout, with a mandatory idle cycle between grants.
module rr_pri_arbiter #(
    parameter int N        = arb_pkg::N,
    parameter int IDXW     = arb_pkg::IDXW,
    parameter int HOLD_MAX = 15,
    parameter int CNTW     = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            mode,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_vld,
    output logic            timeout
);
    import arb_pkg::*;

    localparam logic [CNTW-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : CNTW'(HOLD_MAX - 1);

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (v == {CNTW{1'b1}}) ? v : v + CNTW'(1);
    endfunction

    arb_state_e      state_q, state_d;
    logic [IDXW-1:0] last_q;
    logic [CNTW-1:0] cnt_q;

    logic            any;
    logic [IDXW-1:0] win_idx;
    logic [N-1:0]    win_onehot;

    logic            take;
    logic            rel_now;
    logic            user_rel;
    logic            hold_hit;
    logic            timeout_d;

    rot_pri_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req        (req),
        .last       (last_q),
        .mode       (mode),
        .any        (any),
        .win_idx    (win_idx),
        .win_onehot (win_onehot)
    );

    always_comb begin
        state_d   = state_q;
        take      = 1'b0;
        rel_now   = 1'b0;
        timeout_d = 1'b0;
        user_rel  = done || !req[gnt_idx] || !en;
        hold_hit  = (HOLD_MAX != 0) && (cnt_q == HOLD_LAST);
        unique case (state_q)
            IDLE: begin
                if (en && any) begin
                    state_d = GRANT;
                    take    = 1'b1;
                end
            end
            GRANT: begin
                // Any owner-side reason to release masks the timeout flag.
                if (user_rel || hold_hit) begin
                    state_d   = IDLE;
                    rel_now   = 1'b1;
                    timeout_d = !user_rel;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
            timeout <= 1'b0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timeout <= timeout_d;
            if (take) begin
                gnt     <= win_onehot;
                gnt_idx <= win_idx;
                gnt_vld <= 1'b1;
                last_q  <= win_idx;
                cnt_q   <= '0;
            end else if (rel_now) begin
                gnt     <= '0;
                gnt_idx <= '0;
                gnt_vld <= 1'b0;
                cnt_q   <= '0;
            end else if (state_q == GRANT) begin
                cnt_q   <= sat_inc(cnt_q);
            end
        end
    end

endmodule

// File: tb/tb_rr_pri_arbiter.sv
// Directed bench for rr_pri_arbiter (HOLD_MAX=4): reset, fixed and rotating
// priority, pointer wrap, hold timeout, enable and request-drop release.
module tb_rr_pri_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int passed = 0;
    int total  = 0;

    logic [12:0] obs;
    logic [12:0] exp_v;
    assign obs = {gnt_vld, gnt_idx, gnt, timeout};

    always #5 clk = ~clk;

    rr_pri_arbiter #(
        .N        (8),
        .IDXW     (3),
        .HOLD_MAX (4),
        .CNTW     (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    function automatic logic [12:0] pk(input logic v, input logic [2:0] i,
                                       input logic [7:0] g, input logic t);
        return {v, i, g, t};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0; mode = 1'b0; req = 8'h00; done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        en = 1'b1; req = 8'hFF; mode = 1'b0;
        @(negedge clk);
        exp_v = pk(1'b1, 3'd7, 8'h80, 1'b0);
        total++;
        if (obs !== exp_v) $display("FAIL reset_pre_grant got %h exp %h", obs, exp_v);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        exp_v = pk(1'b0, 3'd0, 8'h00, 1'b0);
        total++;
        if (obs !== exp_v) $display("FAIL reset_async got %h exp %h", obs, exp_v);
        else passed++;
        req = 8'h00; en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fixed();
        @(negedge clk);
        mode = 1'b0; en = 1'b1; req = 8'b0010_1100; done = 1'b0;
        @(negedge clk);
        exp_v = pk(1'b1, 3'd5, 8'h20, 1'b0);
        total++;
        if (obs !== exp_v) $display("FAIL fixed_grant got %h exp %h", obs, exp_v);
        else passed++;
        done = 1'b1;
        @(negedge clk);
        exp_v = pk(1'b0, 3'd0, 8'h00, 1'b0);
        total++;
        if (obs !== exp_v) $display("FAIL fixed_done_release got %h exp %h", obs, exp_v);
        else passed++;
        done = 1'b0;
        @(negedge clk);
        exp_v = pk(1'b1, 3'd5, 8'h20, 1'b0);
        total++;
        if (obs !== exp_v) $display("FAIL fixed_regrant got %h exp %h", obs, exp_v);
        else passed++;
        req = 8'h00;
        @(negedge clk);
        exp_v = pk(1'b0, 3'd0, 8'h00, 1'b0);
        total++;
        if (obs !== exp_v) $display("FAIL fixed_drop_release got %h exp %h", obs, exp_v);
        else passed++;
    endtask

    task automatic test_round_robin();
        logic [2:0] e;
        do_reset();
        mode = 1'b1; en = 1'b1; req = 8'hFF; done = 1'b0;
        for (int i = 0; i < 9; i++) begin
            e = 3'(7 - i);
            @(negedge clk);
            exp_v = pk(1'b1, e, 8'h01 << e, 1'b0);
            total++;
            if (obs !== exp_v) $display("FAIL rr_grant_%0d got %h exp %h", i, obs, exp_v);
            else passed++;
            done = 1'b1;
            @(negedge clk);
            exp_v = pk(1'b0, 3'd0, 8'h00, 1'b0);
            total++;
            if (obs !== exp_v) $display("FAIL rr_gap_%0d got %h exp %h", i, obs, exp_v);
            else passed++;
            done = 1'b0;
        end
        req = 8'h00;
    endtask

    task automatic test_rr_wrap();
        @(negedge clk);
        mode = 1'b1; en = 1'b1; req = 8'h04; done = 1'b0;
        @(negedge clk);
        exp_v = pk(1'b1, 3'd2, 8'h04, 1'b0);
        total++;
        if (obs !== exp_v) $display("FAIL wrap_setup got %h exp %h", obs, exp_v);
        else passed++;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0; req = 8'b1000_0100;
        @(negedge clk);
        exp_v = pk(1'b1, 3'd7, 8'h80, 1'b0);
        total++;
        if (obs !== exp_v) $display("FAIL wrap_first got %h exp %h", obs, exp_v);
        else passed++;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        exp_v = pk(1'b1, 3'd2, 8'h04, 1'b0);
        total++;
        if (obs !== exp_v) $display("FAIL wrap_second got %h exp %h", obs, exp_v);
        else passed++;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0; req = 8'h00;
    endtask

    task automatic test_timeout();
        @(negedge clk);
        mode = 1'b0; en = 1'b1; req = 8'h08; done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            exp_v = pk(1'b1, 3'd3, 8'h08, 1'b0);
            total++;
            if (obs !== exp_v) $display("FAIL timeout_hold_%0d got %h exp %h", c, obs, exp_v);
            else passed++;
        end
        @(negedge clk);
        exp_v = pk(1'b0, 3'd0, 8'h00, 1'b1);
        total++;
        if (obs !== exp_v) $display("FAIL timeout_pulse got %h exp %h", obs, exp_v);
        else passed++;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            exp_v = pk(1'b1, 3'd3, 8'h08, 1'b0);
            total++;
            if (obs !== exp_v) $display("FAIL timeout2_hold_%0d got %h exp %h", c, obs, exp_v);
            else passed++;
        end
        done = 1'b1;
        @(negedge clk);
        exp_v = pk(1'b0, 3'd0, 8'h00, 1'b0);
        total++;
        if (obs !== exp_v) $display("FAIL timeout_done_masks got %h exp %h", obs, exp_v);
        else passed++;
        done = 1'b0; req = 8'h00;
    endtask

    task automatic test_enable_drop();
        @(negedge clk);
        mode = 1'b0; en = 1'b1; req = 8'h40; done = 1'b0;
        @(negedge clk);
        exp_v = pk(1'b1, 3'd6, 8'h40, 1'b0);
        total++;
        if (obs !== exp_v) $display("FAIL drop_grant got %h exp %h", obs, exp_v);
        else passed++;
        req = 8'hF0;
        @(negedge clk);
        total++;
        if (obs !== exp_v) $display("FAIL nonowner_ignored got %h exp %h", obs, exp_v);
        else passed++;
        req = 8'h00;
        @(negedge clk);
        exp_v = pk(1'b0, 3'd0, 8'h00, 1'b0);
        total++;
        if (obs !== exp_v) $display("FAIL drop_release got %h exp %h", obs, exp_v);
        else passed++;
        req = 8'h40;
        @(negedge clk);
        exp_v = pk(1'b1, 3'd6, 8'h40, 1'b0);
        total++;
        if (obs !== exp_v) $display("FAIL en_grant got %h exp %h", obs, exp_v);
        else passed++;
        en = 1'b0;
        @(negedge clk);
        exp_v = pk(1'b0, 3'd0, 8'h00, 1'b0);
        total++;
        if (obs !== exp_v) $display("FAIL en_release got %h exp %h", obs, exp_v);
        else passed++;
        req = 8'hFF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_v) $display("FAIL en_blocks_%0d got %h exp %h", c, obs, exp_v);
            else passed++;
        end
        en = 1'b1;
        @(negedge clk);
        exp_v = pk(1'b1, 3'd7, 8'h80, 1'b0);
        total++;
        if (obs !== exp_v) $display("FAIL en_resume got %h exp %h", obs, exp_v);
        else passed++;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0; req = 8'h00;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0; mode = 1'b0; req = 8'h00; done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_fixed();
        test_round_robin();
        test_rr_wrap();
        test_timeout();
        test_enable_drop();
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rr_pri_arbiter.md
Name: rr_pri_arbiter

Overview:
Sequential arbiter that shares one downstream resource among 8 requesters. Its selection logic is built on the team's 8-to-3 priority-encode function, with highest index winning. It runs in two modes: fixed priority, or rotating (round-robin) priority. Each grant is registered and held until the owner signals completion, drops its request, or exceeds a hold timeout.

Parameters:
N, 8, number of requesters
IDXW, 3, width of grant index (clog2(N))
HOLD_MAX, 15, max cycles a grant may be held; 0 disables timeout
CNTW, 4, width of hold counter (must hold HOLD_MAX)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
en  in  1  arbiter enable; 0 forces release/no new grants
mode  in  1  0 = fixed priority (N-1 highest), 1 = round-robin
req  in  N  request vector, level-sensitive
done  in  1  current owner finished; releases grant
gnt  out  N  one-hot grant, registered
gnt_idx  out  IDXW  index of granted requester; 0 when gnt_vld=0
gnt_vld  out  1  a grant is active
timeout  out  1  one-cycle pulse when a grant is revoked by HOLD_MAX

Behaviour:
- Reset (async, rst_n=0): state=IDLE; gnt=0, gnt_idx=0, gnt_vld=0, timeout=0; rr pointer last=0; hold counter=0. Outputs clear immediately, not at the next edge.
- States: IDLE, GRANT.
- IDLE, en=1 and req!=0: at the next edge go to GRANT and register gnt/gnt_idx/gnt_vld=1 (1-cycle latency from sampled req). Counter is cleared.
- IDLE with en=0 or req=0: stay; outputs 0. done is ignored in IDLE.
- Fixed pick (mode=0): highest set bit of req wins, identical to the priority encoder.
- RR pick (mode=1): search order last-1, last-2, …, 0, N-1, …, last (descending, wrap-around). The first set bit wins.
- RR pointer: last <= winner on every grant, in both modes. With last=0 after reset, the RR order is N-1..0, so it matches fixed priority.
- GRANT: counter increments each cycle. Release at the next edge to IDLE, with all outputs 0, when any of these holds:
  - done=1
  - req[gnt_idx]=0
  - en=0
  - HOLD_MAX!=0 and counter==HOLD_MAX-1, i.e. grant lasted HOLD_MAX cycles
- timeout=1 for exactly the release cycle, only when release is caused by the counter alone. done, req drop, or en=0 in the same cycle take precedence, and timeout stays 0.
- After every release there is a mandatory 1-cycle IDLE gap (gnt_vld=0) before the next grant. Max grant rate is one grant per 2 cycles.
- A mode change takes effect at the next arbitration only and never alters an active grant.
- req changes in non-owner bits during GRANT are ignored.
- Counter saturates and never wraps while in GRANT; it is cleared on entry.
- Reset mid-GRANT: immediate return to reset values. The pointer returns to 0.
- gnt is always one-hot or zero, and gnt_idx is consistent with gnt.

Decomposition:
- Package arb_pkg: state enum {IDLE, GRANT}; localparams N, IDXW; a function onehot_to_idx.
- Sub-module rot_pri_pick (combinational): inputs req, last, mode; outputs any, win_idx, win_onehot. It implements both fixed and rotating search with the double-width-vector technique.
- The top level holds the FSM, pointer, counter and output registers.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with req=8'hFF -> gnt=0, gnt_idx=0, gnt_vld=0, timeout=0 immediately.
- Fixed priority: mode=0, en=1, req=8'b0010_1100 -> one edge later gnt=8'b0010_0000, gnt_idx=5. Then done=1 -> next edge gnt_vld=0, and one cycle later gnt_idx=5 again.
- Round-robin: mode=1, req=8'hFF, done pulsed each grant -> gnt_idx sequence 7,6,5,4,3,2,1,0,7 with a 1-cycle gap between grants.
- Sparse RR wrap: mode=1, last=2, req=8'b1000_0100 -> gnt_idx=7. Next arbitration -> gnt_idx=2.
- Timeout: HOLD_MAX=4, req[3] held, no done -> gnt_vld high exactly 4 cycles, timeout=1 on the release edge. A simultaneous done on that cycle -> timeout stays 0.
- Enable/drop: during a grant of idx 6, drop req[6] (or en=0) -> release at the next edge, timeout=0. With en=0 and req=8'hFF -> no grant issued.
